boot_mem_ctrl: RTL and testbench

//  Clocked, parametrised unified program/data memory for the 8-bit accumulator CPU.

---
 rtl/boot_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_boot_mem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mem_ctrl.sv
// Unified program/data memory for the 8-bit accumulator CPU: zero-clear sweep after reset,
// wait-state CPU handshake and a streaming loader port that has priority over the CPU.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_CLEAR | writing zero to mem[clr_ptr], CPU and loader stalled
// S_IDLE  | accepting loader words (priority) or a CPU request
// S_WAIT  | counting down wait states for the latched CPU access
// S_RESP  | cpu_ready pulse, request not resampled
// S_LOAD  | loader burst in progress, CPU stalled until ld_last
module boot_mem_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 13,
    parameter int DEPTH          = 8192,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              init_done
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP, S_LOAD} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_ptr;
    logic [3:0]        wait_cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ld_go, ld_in, cpu_req, acc_now, acc_wr, acc_in;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata, acc_rdata;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign ld_go   = ld_valid & ld_ready;
    assign ld_in   = {1'b0, ld_addr} < (ADDR_W+1)'(DEPTH);
    assign cpu_req = cpu_rd | cpu_wr;

    // In IDLE a zero-wait access uses the live request; in WAIT the latched copy.
    assign acc_wr    = (state == S_WAIT) ? op_wr    : cpu_wr;
    assign acc_addr  = (state == S_WAIT) ? op_addr  : cpu_addr;
    assign acc_wdata = (state == S_WAIT) ? op_wdata : cpu_wdata;
    assign acc_in    = {1'b0, acc_addr} < (ADDR_W+1)'(DEPTH);
    assign acc_now   = (state == S_IDLE && !ld_go && cpu_req && WAIT_STATES == 0) ||
                       (state == S_WAIT && wait_cnt == 4'd1);
    assign acc_rdata = acc_wr ? acc_wdata :
                       (acc_in ? mem[acc_addr[IDX_W-1:0]] : '0);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (ld_go) begin
            mem_we    = ld_in;
            mem_waddr = ld_addr[IDX_W-1:0];
            mem_wdata = ld_data;
        end else if (acc_now && acc_wr) begin
            mem_we    = acc_in;
            mem_waddr = acc_addr[IDX_W-1:0];
            mem_wdata = acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_ptr   <= '0;
            wait_cnt  <= '0;
            op_wr     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
            busy      <= (CLEAR_ON_RESET != 0);
            init_done <= (CLEAR_ON_RESET == 0);
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + IDX_W'(1);
                    if (clr_ptr == LAST_IDX) begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        ld_ready  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    ld_ready <= 1'b1;
                    if (ld_go) begin
                        if (!ld_last) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end else if (cpu_req) begin
                        op_wr    <= cpu_wr;
                        op_addr  <= cpu_addr;
                        op_wdata <= cpu_wdata;
                        wait_cnt <= 4'(WAIT_STATES);
                        busy     <= 1'b1;
                        ld_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= S_RESP;
                            cpu_ready <= 1'b1;
                            cpu_rdata <= acc_rdata;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state     <= S_RESP;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= acc_rdata;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (ld_go && ld_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Bench for boot_mem_ctrl: two instances (large/zero-wait and small/3-wait) sharing clk and
// rst, checked through a read-data scoreboard plus direct handshake/latency checks.
module tb_boot_mem_ctrl;
    logic clk;
    logic rst;

    logic [1:0][12:0] cpu_addr, ld_addr;
    logic [1:0][7:0]  cpu_wdata, ld_data;
    logic [1:0]       cpu_rd, cpu_wr, ld_valid, ld_last;
    wire  [1:0][7:0]  cpu_rdata;
    wire  [1:0]       cpu_ready, ld_ready, busy, init_done;

    int n_cmp = 0;
    int n_err = 0;

    int dep [2] = '{1024, 16};
    logic [7:0] model [2][1024];
    logic [7:0] img [16];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    boot_mem_ctrl #(.DATA_W(8), .ADDR_W(13), .DEPTH(1024), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_ready(cpu_ready[0]),
        .ld_valid(ld_valid[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_last(ld_last[0]),
        .ld_ready(ld_ready[0]), .busy(busy[0]), .init_done(init_done[0])
    );

    boot_mem_ctrl #(.DATA_W(8), .ADDR_W(13), .DEPTH(16), .WAIT_STATES(3), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_ready(cpu_ready[1]),
        .ld_valid(ld_valid[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_last(ld_last[1]),
        .ld_ready(ld_ready[1]), .busy(busy[1]), .init_done(init_done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic void exp_push(input int s, input logic [7:0] v);
        if (s == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 1024; a++) model[s][a] = 8'd0;
    endfunction

    function automatic void img_model(input int s, input int base, input int nw);
        for (int i = 0; i < nw; i++) model[s][base + i] = img[i];
    endfunction

    // Every cpu_ready pulse must match exactly one outstanding expected read-data value.
    always @(negedge clk) begin
        if (cpu_ready[0]) begin
            if (q0.size() == 0) check("ready0_unexpected", 1, 0);
            else                check("rdata0", cpu_rdata[0], q0.pop_front());
        end
        if (cpu_ready[1]) begin
            if (q1.size() == 0) check("ready1_unexpected", 1, 0);
            else                check("rdata1", cpu_rdata[1], q1.pop_front());
        end
    end

    // Latency counts edges from the first sampling edge up to and including the edge
    // where the CPU sees cpu_ready high and drops its request.
    task automatic cpu_acc(input int s, input bit wr, input bit rd, input int a,
                           input logic [7:0] d, input int exp_lat);
        int n;
        logic [7:0] e;
        n = 0;
        if (wr) begin
            e = d;
            if (a < dep[s]) model[s][a] = d;
        end else begin
            e = (a < dep[s]) ? model[s][a] : 8'd0;
        end
        exp_push(s, e);
        cpu_addr[s]  = 13'(a);
        cpu_wdata[s] = d;
        cpu_wr[s]    = wr;
        cpu_rd[s]    = rd;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (!cpu_ready[s] && n < 100);
        @(posedge clk); n++; @(negedge clk);
        cpu_wr[s] = 1'b0;
        cpu_rd[s] = 1'b0;
        check("cpu_latency", n, exp_lat);
    endtask

    task automatic load_burst(input int s, input int base, input int nw, input int bub);
        int n;
        for (int i = 0; i < nw; i++) begin
            if (i == bub) begin
                ld_valid[s] = 1'b0;
                repeat (2) @(negedge clk);
                check("ld_bubble_hold", busy[s], 1);
            end
            ld_valid[s] = 1'b1;
            ld_addr[s]  = 13'(base + i);
            ld_data[s]  = img[i];
            ld_last[s]  = (i == nw - 1);
            n = 0;
            while (!ld_ready[s] && n < 100) begin
                @(negedge clk); n++;
            end
            if (n >= 100) check("ld_timeout", n, 0);
            @(posedge clk); @(negedge clk);
        end
        ld_valid[s] = 1'b0;
        ld_last[s]  = 1'b0;
        check("ld_exit_idle", busy[s], 0);
    endtask

    task automatic wait_clear();
        int n0, n1;
        n0 = -1;
        n1 = -1;
        for (int n = 1; n <= 2000 && (n0 < 0 || n1 < 0); n++) begin
            @(posedge clk); @(negedge clk);
            if (n0 < 0 && !busy[0]) n0 = n;
            if (n1 < 0 && !busy[1]) n1 = n;
        end
        check("clear_cycles0", n0, 1024);
        check("clear_cycles1", n1, 16);
        check("init_done0", init_done[0], 1);
        check("init_done1", init_done[1], 1);
    endtask

    task automatic check_reset_outputs();
        for (int s = 0; s < 2; s++) begin
            check("rst_busy", busy[s], 1);
            check("rst_init_done", init_done[s], 0);
            check("rst_ld_ready", ld_ready[s], 0);
            check("rst_cpu_ready", cpu_ready[s], 0);
            check("rst_cpu_rdata", cpu_rdata[s], 0);
        end
    endtask

    initial begin
        #500000;
        check("watchdog", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_rd = '0; cpu_wr = '0;
        ld_addr = '0; ld_data = '0; ld_valid = '0; ld_last = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        wait_clear();

        // Sweep left every word of the small instance at zero.
        for (int a = 0; a < 16; a++) cpu_acc(1, 1'b0, 1'b1, a, 8'd0, 5);

        cpu_acc(0, 1'b1, 1'b0, 1001, 8'd130, 2);
        cpu_acc(0, 1'b0, 1'b1, 1001, 8'd0, 2);
        cpu_acc(1, 1'b1, 1'b0, 5, 8'h3C, 5);
        cpu_acc(1, 1'b0, 1'b1, 5, 8'd0, 5);

        img[0] = 8'd5;  img[1] = 8'd130; img[2] = 8'd126; img[3] = 8'd54;  img[4] = 8'd27;
        img[5] = 8'd100; img[6] = 8'd3;  img[7] = 8'd12;  img[8] = 8'd110; img[9] = 8'd15;
        img_model(0, 1000, 10);
        load_burst(0, 1000, 10, 4);
        for (int i = 0; i < 10; i++) cpu_acc(0, 1'b0, 1'b1, 1000 + i, 8'd0, 2);

        // Loader and CPU read collide in IDLE: loader burst goes first, read sees its data.
        img[0] = 8'd201; img[1] = 8'd202; img[2] = 8'd203;
        img_model(0, 1010, 3);
        fork
            load_burst(0, 1010, 3, -1);
            begin
                #1;
                cpu_acc(0, 1'b0, 1'b1, 1012, 8'd0, 5);
            end
        join

        cpu_acc(0, 1'b1, 1'b1, 7, 8'hA5, 2);
        cpu_acc(0, 1'b1, 1'b0, 1500, 8'h77, 2);
        cpu_acc(0, 1'b0, 1'b1, 1500, 8'd0, 2);
        cpu_acc(0, 1'b0, 1'b1, 7, 8'd0, 2);
        cpu_acc(1, 1'b1, 1'b0, 20, 8'h99, 5);
        cpu_acc(1, 1'b0, 1'b1, 20, 8'd0, 5);
        cpu_acc(1, 1'b0, 1'b1, 4, 8'd0, 5);
        cpu_acc(1, 1'b0, 1'b1, 5, 8'd0, 5);

        // Abort: small instance mid-WAIT, large instance mid-LOAD.
        cpu_addr[1] = 13'd5;
        cpu_rd[1]   = 1'b1;
        ld_valid[0] = 1'b1;
        ld_addr[0]  = 13'd1020;
        ld_data[0]  = 8'd9;
        ld_last[0]  = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_abort_busy0", busy[0], 1);
        check("pre_abort_busy1", busy[1], 1);
        check("pre_abort_ld_ready0", ld_ready[0], 1);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        cpu_rd = '0;
        ld_valid = '0;
        repeat (4) @(negedge clk);
        model_clear();
        rst = 1'b0;
        wait_clear();
        cpu_acc(1, 1'b0, 1'b1, 5, 8'd0, 5);
        cpu_acc(0, 1'b0, 1'b1, 1001, 8'd0, 2);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
